// File: rtl/serial_deframer_pkg.sv
// Shared types and constants for the serial deframer.
// Optional feature macro: PARITY_CHECK_EN adds the PARITY state.
package serial_deframer_pkg;

   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] SYNC_PATTERN_DEF = 8'hA5;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1
`ifdef PARITY_CHECK_EN
      ,
      PARITY  = 2'd2
`endif
   } state_t;

endpackage

// File: rtl/deframer_shift8.sv
// 8-bit MSB-first shift register with synchronous clear and shift enable.
module deframer_shift8
   import serial_deframer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              din,
   output logic [BYTE_W-1:0] q
);

   // Clear wins over shift; new bits enter at the LSB end.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (en) begin
         q <= {q[BYTE_W-2:0], din};
      end
   end

endmodule

// File: rtl/serial_deframer.sv
// Serial deframer: hunts for a sync byte, then assembles FRAME_WORDS
// MSB-first data bytes before hunting again.
// Optional feature macro: PARITY_CHECK_EN (one even-parity bit per byte).
module serial_deframer
   import serial_deframer_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
   parameter int                FRAME_WORDS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              din_en,
   output logic [BYTE_W-1:0] data_out,
   output logic              data_valid,
   output logic              sync_lock,
   output logic              parity_err
);

   localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

   state_t            state;
   logic [2:0]        bit_cnt;
   logic [WCW-1:0]    word_cnt;
   logic [BYTE_W-1:0] window_q;
   logic [BYTE_W-1:0] window_next;
   logic [BYTE_W-1:0] data_q;
   logic              hunt_shift;
   logic              collect_shift;
   logic              sync_hit;
   logic              last_word;
   logic              frame_end;

   assign window_next   = {window_q[BYTE_W-2:0], din};
   assign hunt_shift    = din_en && (state == HUNT);
   assign collect_shift = din_en && (state == COLLECT);
   assign sync_hit      = hunt_shift && (window_next == SYNC_PATTERN);
   assign last_word     = (word_cnt == LAST_WORD);

`ifdef PARITY_CHECK_EN
   assign frame_end = din_en && (state == PARITY) && last_word;
`else
   logic [BYTE_W-1:0] data_next;
   assign data_next = {data_q[BYTE_W-2:0], din};
   assign frame_end = collect_shift && (bit_cnt == 3'd7) && last_word;
`endif

   // Sync search window: shifts only while hunting, cleared when a frame ends
   // so a fresh 8 bits are needed before the next match.
   deframer_shift8 u_window (
      .clk (clk),
      .rst (rst),
      .clr (frame_end),
      .en  (hunt_shift),
      .din (din),
      .q   (window_q)
   );

   // Payload shifter: shifts only in COLLECT; parity bits never enter it.
   deframer_shift8 u_data (
      .clk (clk),
      .rst (rst),
      .clr (sync_hit),
      .en  (collect_shift),
      .din (din),
      .q   (data_q)
   );

   // Frame FSM with registered outputs; valid/error are single-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         sync_lock  <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err <= 1'b0;
`endif
      end else begin
         data_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err <= 1'b0;
`endif
         case (state)
            HUNT: begin
               if (sync_hit) begin
                  state     <= COLLECT;
                  bit_cnt   <= '0;
                  word_cnt  <= '0;
                  sync_lock <= 1'b1;
               end
            end
            COLLECT: begin
               if (din_en) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef PARITY_CHECK_EN
                     state <= PARITY;
`else
                     data_out   <= data_next;
                     data_valid <= 1'b1;
                     if (last_word) begin
                        state     <= HUNT;
                        sync_lock <= 1'b0;
                     end else begin
                        word_cnt <= word_cnt + 1'b1;
                     end
`endif
                  end
               end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
               if (din_en) begin
                  data_out   <= data_q;
                  data_valid <= 1'b1;
                  parity_err <= ^{data_q, din};
                  if (last_word) begin
                     state     <= HUNT;
                     sync_lock <= 1'b0;
                  end else begin
                     state    <= COLLECT;
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
`endif
            default: begin
               state <= HUNT;
            end
         endcase
      end
   end

`ifndef PARITY_CHECK_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer: two instances (FRAME_WORDS=1 and 2)
// share one input stream and are compared every cycle to a bit-level model.
// Honors PARITY_CHECK_EN when the build defines it.
module tb_serial_deframer;

`ifdef PARITY_CHECK_EN
   localparam int BPW = 9;
`else
   localparam int BPW = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       din_en = 1'b0;
   logic [7:0] dout1, dout2;
   logic       dv1, dv2, sl1, sl2, pe1, pe2;

   serial_deframer #(.SYNC_PATTERN(8'hA5), .FRAME_WORDS(1)) dut1 (
      .clk(clk), .rst(rst), .din(din), .din_en(din_en),
      .data_out(dout1), .data_valid(dv1), .sync_lock(sl1), .parity_err(pe1)
   );

   serial_deframer #(.SYNC_PATTERN(8'hA5), .FRAME_WORDS(2)) dut2 (
      .clk(clk), .rst(rst), .din(din), .din_en(din_en),
      .data_out(dout2), .data_valid(dv2), .sync_lock(sl2), .parity_err(pe2)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state per instance: locked flag, window, payload accumulator,
   // bits consumed in the current frame, last byte, expected pulses.
   int fw_of[2] = '{1, 2};
   int m_lock[2], m_win[2], m_acc[2], m_nbits[2], m_dout[2];
   int e_vld[2], e_perr[2];
   int vcount[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input int i, input bit r, input bit en, input bit b);
      e_vld[i]  = 0;
      e_perr[i] = 0;
      if (r) begin
         m_lock[i] = 0; m_win[i] = 0; m_acc[i] = 0; m_nbits[i] = 0; m_dout[i] = 0;
         return;
      end
      if (!en) return;
      if (m_lock[i] == 0) begin
         m_win[i] = ((m_win[i] << 1) | int'(b)) & 255;
         if (m_win[i] == 8'hA5) begin
            m_lock[i]  = 1;
            m_nbits[i] = 0;
         end
      end else begin
         if ((m_nbits[i] % BPW) < 8) m_acc[i] = ((m_acc[i] << 1) | int'(b)) & 255;
         m_nbits[i]++;
         if ((m_nbits[i] % BPW) == 0) begin
            m_dout[i] = m_acc[i];
            e_vld[i]  = 1;
            if (BPW == 9) e_perr[i] = ($countones(m_acc[i]) + int'(b)) % 2;
            if (m_nbits[i] == fw_of[i] * BPW) begin
               m_lock[i] = 0;
               m_win[i]  = 0;
            end
         end
      end
   endtask

   task automatic tick(input bit r, input bit en, input bit b);
      rst = r; din_en = en; din = b;
      model_step(0, r, en, b);
      model_step(1, r, en, b);
      @(posedge clk);
      #1;
      chk("fw1_valid", {31'd0, dv1}, e_vld[0]);
      chk("fw1_data",  {24'd0, dout1}, m_dout[0]);
      chk("fw1_lock",  {31'd0, sl1}, m_lock[0]);
      chk("fw1_perr",  {31'd0, pe1}, e_perr[0]);
      chk("fw2_valid", {31'd0, dv2}, e_vld[1]);
      chk("fw2_data",  {24'd0, dout2}, m_dout[1]);
      chk("fw2_lock",  {31'd0, sl2}, m_lock[1]);
      chk("fw2_perr",  {31'd0, pe2}, e_perr[1]);
      if (dv1 === 1'b1) vcount[0]++;
      if (dv2 === 1'b1) vcount[1]++;
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1);   // reset must win over a live strobe
      vcount[0] = 0;
      vcount[1] = 0;
   endtask

   task automatic send_byte(input logic [7:0] v, input bit gaps);
      for (int k = 7; k >= 0; k--) begin
         if (gaps) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         tick(1'b0, 1'b1, v[k]);
      end
   endtask

   // A payload byte followed, in parity builds, by its correct even-parity bit.
   task automatic send_word(input logic [7:0] v, input bit gaps);
      send_byte(v, gaps);
`ifdef PARITY_CHECK_EN
      tick(1'b0, 1'b1, ^v);
`endif
   endtask

   initial begin
      do_reset();

      // Basic frame, strobe every cycle
      send_byte(8'hA5, 1'b0);
      chk("basic_lock_after_sync", {31'd0, sl1}, 32'd1);
      send_word(8'h3C, 1'b0);
      chk("basic_pulses", vcount[0], 32'd1);
      chk("basic_lock_dropped", {31'd0, sl1}, 32'd0);
      chk("basic_byte", {24'd0, dout1}, 32'h3C);
      send_word(8'h5A, 1'b0);
      chk("fw2_pulses", vcount[1], 32'd2);

      // Gapped strobe
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_word(8'h3C, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      chk("gapped_pulses", vcount[0], 32'd1);
      chk("gapped_byte", {24'd0, dout1}, 32'h3C);

      // Sync byte inside payload
      do_reset();
      send_byte(8'hA5, 1'b0);
      send_word(8'hA5, 1'b0);
      chk("payload_sync_byte", {24'd0, dout2}, 32'hA5);
      chk("payload_no_relock", {31'd0, sl2}, 32'd1);
      send_word(8'h0F, 1'b0);
      chk("payload_last_byte", {24'd0, dout2}, 32'h0F);
      chk("payload_pulses", vcount[1], 32'd2);

      // Reset mid-word
      do_reset();
      send_byte(8'hA5, 1'b0);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      vcount[0] = 0;
      vcount[1] = 0;
      send_word(8'h3C, 1'b0);
      chk("midreset_pulses", vcount[0] + vcount[1], 32'd0);
      chk("midreset_lock", {31'd0, sl1}, 32'd0);

      // Near-miss: A4 then a 1 forms 49
      do_reset();
      send_byte(8'hA4, 1'b0);
      tick(1'b0, 1'b1, 1'b1);
      chk("nearmiss_lock", {31'd0, sl1}, 32'd0);

`ifdef PARITY_CHECK_EN
      // Parity good then bad
      do_reset();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h81, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      chk("parity_good_err", {31'd0, pe1}, 32'd0);
      chk("parity_good_vld", {31'd0, dv1}, 32'd1);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h81, 1'b0);
      tick(1'b0, 1'b1, 1'b1);
      chk("parity_bad_err", {31'd0, pe1}, 32'd1);
      chk("parity_bad_vld", {31'd0, dv1}, 32'd1);
`endif

      // Randomized traffic with frequent sync injection
      do_reset();
      for (int it = 0; it < 400; it++) begin
         int sel;
         sel = int'($urandom_range(0, 99));
         if (sel < 3) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else if (sel < 30) begin
            send_byte(8'hA5, 1'($urandom_range(0, 1)));
         end else begin
            for (int k = 0; k < 8; k++)
               tick(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_deframer.md
SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SYNC_PATTERN, 8'hA5, sync byte that starts a frame.
- FRAME_WORDS, 4, data bytes per frame; minimum 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous, active-high reset.
- din, in, 1, serial bit from the upstream sync-clear flip-flop q output, MSB first.
- din_en, in, 1, bit strobe; din is sampled only when din_en=1.
- data_out, out, 8, last assembled byte.
- data_valid, out, 1, one-cycle pulse marking a new data_out.
- sync_lock, out, 1, high while a frame is in progress.
- parity_err, out, 1, one-cycle pulse with data_valid on parity mismatch (only with PARITY_CHECK_EN).
REQ-003 Clock and reset SHALL be exactly as decided: one clock (clk); reset (rst) is synchronous and active-high.

Function
REQ-004 FSM states SHALL be HUNT, COLLECT and PARITY (PARITY exists only with PARITY_CHECK_EN).
REQ-005 HUNT: each din_en cycle SHALL shift din into an 8-bit window, as window = {window[6:0], din}.
REQ-006 HUNT -> COLLECT SHALL occur on the edge where the updated window equals SYNC_PATTERN; that edge SHALL clear the bit count and the word count, and set sync_lock=1.
REQ-007 COLLECT: each din_en cycle SHALL shift din into the data shifter, MSB first, and increment the bit count from 0 to 7.
REQ-008 On the edge that samples bit 7, data_out SHALL load the assembled byte and data_valid SHALL be 1 for exactly the next cycle (latency 1 clk from the last sampled bit).
REQ-009 After word FRAME_WORDS, the FSM SHALL return to HUNT, sync_lock SHALL drop to 0, and the window SHALL be cleared to 8'h00.
REQ-010 With din_en=0, all state, counters and shifters SHALL hold; data_valid SHALL be 0.
REQ-011 SYNC_PATTERN bits inside the payload SHALL NOT be re-detected while in COLLECT or PARITY.
REQ-012 Between valid pulses, data_out SHALL hold its last value.
REQ-013 Back-to-back din_en on every cycle SHALL be supported with no lost bits.

Reset
REQ-014 When rst=1 at a posedge, the block SHALL set state=HUNT, window=0, all counters=0, data_out=8'h00, data_valid=0, sync_lock=0 and parity_err=0.
REQ-015 Reset mid-word SHALL discard the partial byte; no data_valid pulse SHALL follow.
REQ-016 After reset, a full 8 fresh bits SHALL be needed before the sync pattern can match.
REQ-017 rst SHALL take priority over din_en when both are high on the same edge.

Configuration
REQ-018 The macro SHALL be PARITY_CHECK_EN.
- Defined: after bit 7 the FSM SHALL enter PARITY, which consumes one even-parity bit.
- data_valid and parity_err SHALL pulse on the cycle after the parity bit is sampled.
- parity_err = 1 SHALL mean XOR(byte, parity bit) = 1.
REQ-019 PARITY_CHECK_EN undefined: there SHALL be no PARITY state, and parity_err SHALL be tied to 0.

Structure
REQ-020 Package serial_deframer_pkg SHALL hold the state enum, the default SYNC_PATTERN constant and the byte width constant (8).
REQ-021 The 8-bit shift register with synchronous clear and shift enable SHALL be sub-module deframer_shift8; it SHALL be instantiated twice (window and data).

Verification
REQ-022 Basic frame (FRAME_WORDS=1): shift in A5 then 3C with din_en=1 every cycle -> one data_valid pulse with data_out=8'h3C; sync_lock rises after the sync byte and falls after 3C.
REQ-023 Gapped strobe: same bits with din_en toggling every other cycle -> identical data_out and a single pulse; no pulse or state change while din_en=0.
REQ-024 Payload containing sync (FRAME_WORDS=2): send A5, A5, 0F -> data_valid pulses with data_out A5 then 0F; no resync.
REQ-025 Reset mid-word: send A5 and 4 data bits, assert rst for 1 cycle, then send 3C -> no data_valid; sync_lock=0 and the FSM is in HUNT.
REQ-026 Parity (PARITY_CHECK_EN defined): A5, 8'h81, parity 0 -> valid with parity_err=0; A5, 8'h81, parity 1 -> valid with parity_err=1.
REQ-027 Near-miss: send A4 followed by one more bit forming 49 -> no lock; sync_lock stays 0.
